// File: rtl/system_qsys_lcd_bus_ctrl_pkg.sv
// Shared types and constants for the 8080-style LCD bus controller.
package system_qsys_lcd_bus_pkg;

    // Width of the per-phase down-counter
    localparam int PH_CNT_W = 8;

    // Avalon word addresses
    localparam logic [1:0] ADDR_CMD  = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_RD   = 2'd2;
    localparam logic [1:0] ADDR_FILL = 2'd3;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_LO = 3'd1,
        ST_WR_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_RD_HI = 3'd4,
        ST_DONE  = 3'd5
    } lcd_state_t;

    // Phase length in cycles -> counter load value (counter ends the phase at 0)
    function automatic logic [PH_CNT_W-1:0] ph_load(input int cyc);
        return PH_CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/system_qsys_lcd_bus_ctrl_if.sv
// Avalon-MM slave port plus LCD pin bundle for the LCD bus controller.
interface system_qsys_lcd_bus_ctrl_if;

    logic [1:0]  avs_address;
    logic        avs_write;
    logic        avs_read;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;
    logic [15:0] lcd_data_in;

    // Controller side
    modport slave (
        input  avs_address, avs_write, avs_read, avs_writedata, lcd_data_in,
        output avs_readdata, avs_waitrequest,
        output lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_out, lcd_data_oe
    );

    // CPU + pad side
    modport master (
        output avs_address, avs_write, avs_read, avs_writedata, lcd_data_in,
        input  avs_readdata, avs_waitrequest,
        input  lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_out, lcd_data_oe
    );

endinterface

// File: rtl/system_qsys_lcd_bus_timer.sv
// Loadable phase down-counter; o_expire is high in the last cycle of a phase.
module system_qsys_lcd_bus_timer
    import system_qsys_lcd_bus_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [PH_CNT_W-1:0] i_load_val,
    output logic                o_expire
);

    logic [PH_CNT_W-1:0] r_cnt;
    logic                r_run;

    // Load on phase entry, count down while running, stop after reaching zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0)
                r_run <= 1'b0;
            else
                r_cnt <= r_cnt - PH_CNT_W'(1);
        end
    end

    assign o_expire = r_run & (r_cnt == '0);

endmodule

// File: rtl/system_qsys_lcd_bus_ctrl.sv
// Avalon-MM slave that sequences 8080-style LCD write/read bus cycles.
// Optional feature macro LCD_BUS_CTRL_FILL_EN: a write to address 3 issues
// writedata[31:16]+1 back-to-back data writes under one CS# window.
module system_qsys_lcd_bus_ctrl
    import system_qsys_lcd_bus_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    system_qsys_lcd_bus_ctrl_if.slave    bus
);

    localparam logic [PH_CNT_W-1:0] WL_LD = ph_load(WR_LOW_CYC);
    localparam logic [PH_CNT_W-1:0] WH_LD = ph_load(WR_HIGH_CYC);
    localparam logic [PH_CNT_W-1:0] RL_LD = ph_load(RD_LOW_CYC);
    localparam logic [PH_CNT_W-1:0] RH_LD = ph_load(RD_HIGH_CYC);

    lcd_state_t          r_state;
    logic                r_cs_n;
    logic                r_rs;
    logic                r_wr_n;
    logic                r_rd_n;
    logic                r_oe;
    logic [15:0]         r_dout;
    logic [31:0]         r_rdata;

    logic                w_req;
    logic                w_wr_bus;
    logic                w_wr_fill;
    logic                w_wr_start;
    logic                w_rd_bus;
    logic                w_more;
    logic                w_expire;
    logic                w_load;
    logic [PH_CNT_W-1:0] w_load_val;

    // Request decode; a simultaneous read and write is treated as the write
    assign w_req      = bus.avs_read | bus.avs_write;
    assign w_wr_bus   = bus.avs_write & ((bus.avs_address == ADDR_CMD) |
                                         (bus.avs_address == ADDR_DATA));
    assign w_rd_bus   = ~bus.avs_write & bus.avs_read & (bus.avs_address == ADDR_RD);
    assign w_wr_start = w_wr_bus | w_wr_fill;

`ifdef LCD_BUS_CTRL_FILL_EN
    logic [15:0] r_fill_cnt;

    assign w_wr_fill = bus.avs_write & (bus.avs_address == ADDR_FILL);
    assign w_more    = |r_fill_cnt;

    // Remaining writes after the current one; zero for ordinary writes
    always_ff @(posedge clk) begin
        if (reset)
            r_fill_cnt <= '0;
        else if (r_state == ST_IDLE && w_wr_fill)
            r_fill_cnt <= bus.avs_writedata[31:16];
        else if (r_state == ST_IDLE && w_wr_bus)
            r_fill_cnt <= '0;
        else if (r_state == ST_WR_HI && w_expire && w_more)
            r_fill_cnt <= r_fill_cnt - 16'd1;
    end
`else
    // Address 3 is a no-op write in this build
    assign w_wr_fill = 1'b0;
    assign w_more    = 1'b0;
`endif

    // Phase counter load: on entry to every timed phase
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_start) begin
                    w_load     = 1'b1;
                    w_load_val = WL_LD;
                end else if (w_rd_bus) begin
                    w_load     = 1'b1;
                    w_load_val = RL_LD;
                end
            end
            ST_WR_LO: begin
                if (w_expire) begin
                    w_load     = 1'b1;
                    w_load_val = WH_LD;
                end
            end
            ST_WR_HI: begin
                if (w_expire && w_more) begin
                    w_load     = 1'b1;
                    w_load_val = WL_LD;
                end
            end
            ST_RD_LO: begin
                if (w_expire) begin
                    w_load     = 1'b1;
                    w_load_val = RH_LD;
                end
            end
            default: ;
        endcase
    end

    system_qsys_lcd_bus_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    // Bus-cycle sequencer with registered pin outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_rs    <= 1'b0;
            r_oe    <= 1'b0;
            r_dout  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_start) begin
                        r_state <= ST_WR_LO;
                        r_cs_n  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_rs    <= (bus.avs_address != ADDR_CMD);
                        r_dout  <= bus.avs_writedata[15:0];
                        r_oe    <= 1'b1;
                    end else if (w_rd_bus) begin
                        r_state <= ST_RD_LO;
                        r_cs_n  <= 1'b0;
                        r_rd_n  <= 1'b0;
                        r_rs    <= 1'b1;
                        r_oe    <= 1'b0;
                    end else if (w_req) begin
                        // Unmapped access: complete immediately, reads return 0
                        r_state <= ST_DONE;
                        if (!bus.avs_write)
                            r_rdata <= '0;
                    end
                end
                ST_WR_LO: begin
                    if (w_expire) begin
                        r_state <= ST_WR_HI;
                        r_wr_n  <= 1'b1;
                    end
                end
                ST_WR_HI: begin
                    if (w_expire) begin
                        if (w_more) begin
                            r_state <= ST_WR_LO;
                            r_wr_n  <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_cs_n  <= 1'b1;
                        end
                    end
                end
                ST_RD_LO: begin
                    if (w_expire) begin
                        r_state <= ST_RD_HI;
                        r_rd_n  <= 1'b1;
                        r_rdata <= {16'h0000, bus.lcd_data_in};
                    end
                end
                ST_RD_HI: begin
                    if (w_expire) begin
                        r_state <= ST_DONE;
                        r_cs_n  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_oe    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.avs_waitrequest = w_req & (r_state != ST_DONE);
    assign bus.avs_readdata    = r_rdata;
    assign bus.lcd_cs_n        = r_cs_n;
    assign bus.lcd_rs          = r_rs;
    assign bus.lcd_wr_n        = r_wr_n;
    assign bus.lcd_rd_n        = r_rd_n;
    assign bus.lcd_data_out    = r_dout;
    assign bus.lcd_data_oe     = r_oe;

endmodule

// File: tb/tb_system_qsys_lcd_bus_ctrl.sv
// Directed bench for system_qsys_lcd_bus_ctrl (default timing 2/2/4/2).
module tb_system_qsys_lcd_bus_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pad_pat = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    system_qsys_lcd_bus_ctrl_if bus();

    // LCD pad model: drives 0x9341 while RD# is low, 0xFFFF once it rises
    assign bus.lcd_data_in = pad_pat ? (bus.lcd_rd_n ? 16'hFFFF : 16'h9341) : 16'h5A5A;

    system_qsys_lcd_bus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Per-cycle pin trace, index = cycles after the request was presented
    logic        tr_cs [0:63];
    logic        tr_wr [0:63];
    logic        tr_rd [0:63];
    logic        tr_rs [0:63];
    logic        tr_oe [0:63];
    logic        tr_wq [0:63];
    logic [15:0] tr_do [0:63];
    logic [31:0] tr_rdat [0:63];
    int          done1;
    int          done2;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rec(input int k);
        tr_cs[k]   = bus.lcd_cs_n;
        tr_wr[k]   = bus.lcd_wr_n;
        tr_rd[k]   = bus.lcd_rd_n;
        tr_rs[k]   = bus.lcd_rs;
        tr_oe[k]   = bus.lcd_data_oe;
        tr_wq[k]   = bus.avs_waitrequest;
        tr_do[k]   = bus.lcd_data_out;
        tr_rdat[k] = bus.avs_readdata;
    endtask

    // Avalon master: present a request, hold until waitrequest drops, then
    // optionally issue a second write one cycle later; trace maxc cycles.
    task automatic run_txn(input logic wr, input logic rd, input logic [1:0] addr,
                           input logic [31:0] wd, input logic nxt,
                           input logic [31:0] nwd, input int maxc);
        int ph;
        done1 = -1;
        done2 = -1;
        rec(0);
        bus.avs_write     = wr;
        bus.avs_read      = rd;
        bus.avs_address   = addr;
        bus.avs_writedata = wd;
        ph = 0;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            rec(k);
            if (ph == 0 && !tr_wq[k]) begin
                done1 = k;
                bus.avs_write = 1'b0;
                bus.avs_read  = 1'b0;
                ph = nxt ? 1 : 3;
            end else if (ph == 1) begin
                bus.avs_write     = 1'b1;
                bus.avs_writedata = nwd;
                ph = 2;
            end else if (ph == 2 && !tr_wq[k]) begin
                done2 = k;
                bus.avs_write = 1'b0;
                ph = 3;
            end
        end
        bus.avs_write = 1'b0;
        bus.avs_read  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.lcd_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", bus.lcd_cs_n); end
        n_cmp++; if (bus.lcd_wr_n !== 1'b1) begin n_bad++; $display("FAIL rst_wr_n: got %b want 1", bus.lcd_wr_n); end
        n_cmp++; if (bus.lcd_rd_n !== 1'b1) begin n_bad++; $display("FAIL rst_rd_n: got %b want 1", bus.lcd_rd_n); end
        n_cmp++; if (bus.lcd_rs !== 1'b0) begin n_bad++; $display("FAIL rst_rs: got %b want 0", bus.lcd_rs); end
        n_cmp++; if (bus.lcd_data_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", bus.lcd_data_oe); end
        n_cmp++; if (bus.lcd_data_out !== 16'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 0000", bus.lcd_data_out); end
        n_cmp++; if (bus.avs_readdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.avs_readdata); end
        n_cmp++; if (bus.avs_waitrequest !== 1'b0) begin n_bad++; $display("FAIL rst_wq: got %b want 0", bus.avs_waitrequest); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cmd_write();
        logic [2:0] e;
        run_txn(1'b1, 1'b0, 2'd0, 32'h0000_002C, 1'b0, 32'h0, 8);
        n_cmp++; if (done1 !== 5) begin n_bad++; $display("FAIL cmd_done: got %0d want 5", done1); end
        for (int k = 1; k <= 7; k++) begin
            e = {(k <= 4) ? 1'b0 : 1'b1, (k <= 2) ? 1'b0 : 1'b1, 1'b1};
            n_cmp++;
            if ({tr_cs[k], tr_wr[k], tr_rd[k]} !== e) begin
                n_bad++; $display("FAIL cmd_pins[%0d] cs/wr/rd: got %b want %b", k, {tr_cs[k], tr_wr[k], tr_rd[k]}, e);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({tr_oe[k], tr_rs[k], tr_do[k]} !== {1'b1, 1'b0, 16'h002C}) begin
                n_bad++; $display("FAIL cmd_bus[%0d] oe/rs/data: got %b/%b/%h want 1/0/002c", k, tr_oe[k], tr_rs[k], tr_do[k]);
            end
        end
        n_cmp++; if (tr_oe[6] !== 1'b0) begin n_bad++; $display("FAIL cmd_oe_idle: got %b want 0", tr_oe[6]); end
        n_cmp++; if (tr_wq[4] !== 1'b1) begin n_bad++; $display("FAIL cmd_wq_t4: got %b want 1", tr_wq[4]); end
        n_cmp++; if (tr_wq[5] !== 1'b0) begin n_bad++; $display("FAIL cmd_wq_t5: got %b want 0", tr_wq[5]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        run_txn(1'b1, 1'b0, 2'd1, 32'h0000_F800, 1'b1, 32'h0000_07E0, 14);
        n_cmp++; if (done1 !== 5) begin n_bad++; $display("FAIL b2b_done1: got %0d want 5", done1); end
        n_cmp++; if (done2 !== 11) begin n_bad++; $display("FAIL b2b_done2: got %0d want 11", done2); end
        for (int k = 1; k <= 13; k++) begin
            e[1] = !((k >= 1 && k <= 4) || (k >= 7 && k <= 10));
            e[0] = !(k == 1 || k == 2 || k == 7 || k == 8);
            n_cmp++;
            if ({tr_cs[k], tr_wr[k]} !== e) begin
                n_bad++; $display("FAIL b2b_pins[%0d] cs/wr: got %b want %b", k, {tr_cs[k], tr_wr[k]}, e);
            end
        end
        n_cmp++; if (tr_do[3] !== 16'hF800) begin n_bad++; $display("FAIL b2b_data1: got %h want f800", tr_do[3]); end
        n_cmp++; if (tr_do[9] !== 16'h07E0) begin n_bad++; $display("FAIL b2b_data2: got %h want 07e0", tr_do[9]); end
        n_cmp++; if (tr_rs[9] !== 1'b1) begin n_bad++; $display("FAIL b2b_rs: got %b want 1", tr_rs[9]); end
    endtask

    task automatic test_read();
        logic [2:0] e;
        pad_pat = 1'b1;
        run_txn(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h0, 9);
        n_cmp++; if (done1 !== 7) begin n_bad++; $display("FAIL rd_done: got %0d want 7", done1); end
        for (int k = 1; k <= 8; k++) begin
            e = {(k <= 6) ? 1'b0 : 1'b1, (k <= 4) ? 1'b0 : 1'b1, 1'b1};
            n_cmp++;
            if ({tr_cs[k], tr_rd[k], tr_wr[k]} !== e) begin
                n_bad++; $display("FAIL rd_pins[%0d] cs/rd/wr: got %b want %b", k, {tr_cs[k], tr_rd[k], tr_wr[k]}, e);
            end
            n_cmp++;
            if (tr_oe[k] !== 1'b0) begin n_bad++; $display("FAIL rd_oe[%0d]: got %b want 0", k, tr_oe[k]); end
        end
        n_cmp++; if (tr_rs[2] !== 1'b1) begin n_bad++; $display("FAIL rd_rs: got %b want 1", tr_rs[2]); end
        n_cmp++; if (tr_rdat[7] !== 32'h0000_9341) begin n_bad++; $display("FAIL rd_data: got %h want 00009341", tr_rdat[7]); end
        n_cmp++; if (tr_rdat[9] !== 32'h0000_9341) begin n_bad++; $display("FAIL rd_hold: got %h want 00009341", tr_rdat[9]); end
        pad_pat = 1'b0;
    endtask

    task automatic test_dummy();
        int act;
        run_txn(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 5);
        act = 0;
        for (int k = 1; k <= 5; k++) if (!tr_cs[k] || !tr_wr[k] || !tr_rd[k]) act++;
        n_cmp++; if (done1 !== 1) begin n_bad++; $display("FAIL dmy_rd0_done: got %0d want 1", done1); end
        n_cmp++; if (tr_rdat[1] !== 32'h0) begin n_bad++; $display("FAIL dmy_rd0_data: got %h want 0", tr_rdat[1]); end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL dmy_rd0_pins: got %0d active cycles want 0", act); end
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_1111, 1'b0, 32'h0, 5);
        act = 0;
        for (int k = 1; k <= 5; k++) if (!tr_cs[k] || !tr_wr[k] || !tr_rd[k] || tr_oe[k]) act++;
        n_cmp++; if (done1 !== 1) begin n_bad++; $display("FAIL dmy_wr2_done: got %0d want 1", done1); end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL dmy_wr2_pins: got %0d active cycles want 0", act); end
    endtask

    task automatic test_rw_collision();
        int act;
        run_txn(1'b1, 1'b1, 2'd1, 32'h0000_0055, 1'b0, 32'h0, 7);
        n_cmp++; if (done1 !== 5) begin n_bad++; $display("FAIL rw_wr_done: got %0d want 5", done1); end
        n_cmp++; if ({tr_wr[1], tr_rd[1], tr_do[1]} !== {1'b0, 1'b1, 16'h0055}) begin
            n_bad++; $display("FAIL rw_wr_pins: got wr=%b rd=%b d=%h want 0/1/0055", tr_wr[1], tr_rd[1], tr_do[1]);
        end
        run_txn(1'b1, 1'b1, 2'd2, 32'h0, 1'b0, 32'h0, 5);
        act = 0;
        for (int k = 1; k <= 5; k++) if (!tr_cs[k] || !tr_rd[k]) act++;
        n_cmp++; if (done1 !== 1) begin n_bad++; $display("FAIL rw_a2_done: got %0d want 1", done1); end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL rw_a2_pins: got %0d active cycles want 0", act); end
    endtask

    task automatic test_reset_mid();
        bus.avs_write     = 1'b1;
        bus.avs_read      = 1'b0;
        bus.avs_address   = 2'd1;
        bus.avs_writedata = 32'h0000_1234;
        tick();
        n_cmp++; if (bus.lcd_cs_n !== 1'b0) begin n_bad++; $display("FAIL rmid_start: got cs_n %b want 0", bus.lcd_cs_n); end
        tick();
        reset = 1'b1;
        bus.avs_write = 1'b0;
        tick();
        n_cmp++; if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n} !== 3'b111) begin
            n_bad++; $display("FAIL rmid_strobes: got %b want 111", {bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n});
        end
        n_cmp++; if ({bus.lcd_data_oe, bus.lcd_rs, bus.lcd_data_out} !== 18'h0) begin
            n_bad++; $display("FAIL rmid_bus: got oe=%b rs=%b d=%h want 0/0/0000", bus.lcd_data_oe, bus.lcd_rs, bus.lcd_data_out);
        end
        reset = 1'b0;
        run_txn(1'b1, 1'b0, 2'd1, 32'h0000_BEEF, 1'b0, 32'h0, 7);
        n_cmp++; if (done1 !== 5) begin n_bad++; $display("FAIL rmid_fresh_done: got %0d want 5", done1); end
        n_cmp++; if ({tr_cs[1], tr_wr[1], tr_do[1]} !== {1'b0, 1'b0, 16'hBEEF}) begin
            n_bad++; $display("FAIL rmid_fresh_pins: got cs=%b wr=%b d=%h want 0/0/beef", tr_cs[1], tr_wr[1], tr_do[1]);
        end
        n_cmp++; if (tr_wr[3] !== 1'b1) begin n_bad++; $display("FAIL rmid_fresh_wrhi: got %b want 1", tr_wr[3]); end
    endtask

    task automatic test_fill();
        int pulses;
        int cs_lo;
        run_txn(1'b1, 1'b0, 2'd3, 32'h0003_001F, 1'b0, 32'h0, 20);
        pulses = 0;
        cs_lo  = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!tr_wr[k] && tr_wr[k-1]) pulses++;
            if (!tr_cs[k]) cs_lo++;
        end
`ifdef LCD_BUS_CTRL_FILL_EN
        n_cmp++; if (done1 !== 17) begin n_bad++; $display("FAIL fill_done: got %0d want 17", done1); end
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL fill_pulses: got %0d want 4", pulses); end
        n_cmp++; if (cs_lo !== 16) begin n_bad++; $display("FAIL fill_cs_low: got %0d want 16", cs_lo); end
        n_cmp++; if ({tr_cs[16], tr_cs[17]} !== 2'b01) begin n_bad++; $display("FAIL fill_cs_edge: got %b want 01", {tr_cs[16], tr_cs[17]}); end
        n_cmp++; if ({tr_rs[10], tr_oe[10], tr_do[10]} !== {1'b1, 1'b1, 16'h001F}) begin
            n_bad++; $display("FAIL fill_bus: got rs=%b oe=%b d=%h want 1/1/001f", tr_rs[10], tr_oe[10], tr_do[10]);
        end
        n_cmp++; if (tr_wq[16] !== 1'b1) begin n_bad++; $display("FAIL fill_wq: got %b want 1", tr_wq[16]); end
`else
        n_cmp++; if (done1 !== 1) begin n_bad++; $display("FAIL fill_off_done: got %0d want 1", done1); end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL fill_off_pulses: got %0d want 0", pulses); end
        n_cmp++; if (cs_lo !== 0) begin n_bad++; $display("FAIL fill_off_cs: got %0d want 0", cs_lo); end
`endif
    endtask

    initial begin
        bus.avs_write     = 1'b0;
        bus.avs_read      = 1'b0;
        bus.avs_address   = 2'd0;
        bus.avs_writedata = 32'h0;
        test_reset();
        test_cmd_write();
        test_back_to_back();
        test_read();
        test_dummy();
        test_rw_collision();
        test_reset_mid();
        test_fill();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the run never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end

endmodule

// File: doc/system_qsys_lcd_bus_ctrl.md
Name: system_qsys_lcd_bus_ctrl

Overview:
- Avalon-MM slave that sequences an 8080-style parallel LCD bus: CS#, RS, WR#, RD# and a 16-bit tri-stated data bus.
- Sits in system_qsys between the Nios II data master and the LCD pins.
- Replaces the software-bit-banged PIO strobes plus the raw 16-bit lcd data input port; it samples that same input bus during read cycles.
- Bus-cycle pulse widths are fixed by parameters; the CPU stalls through waitrequest until each cycle completes.

Parameters:
- WR_LOW_CYC, 2, clk cycles WR# held low (1..255)
- WR_HIGH_CYC, 2, clk cycles WR# high before CS# release (1..255)
- RD_LOW_CYC, 4, clk cycles RD# held low (1..255)
- RD_HIGH_CYC, 2, clk cycles RD# high before CS# release (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avs_address  in  2  0 = command write (RS=0), 1 = data write (RS=1), 2 = data read (RS=1), 3 = fill
- avs_write  in  1  Avalon write request
- avs_read  in  1  Avalon read request
- avs_writedata  in  32  [15:0] bus word; [31:16] fill count-1 (fill only)
- avs_readdata  out  32  {16'b0, sampled word}
- avs_waitrequest  out  1  high until the transaction completes
- lcd_cs_n  out  1  chip select, active low
- lcd_rs  out  1  register select
- lcd_wr_n  out  1  write strobe
- lcd_rd_n  out  1  read strobe
- lcd_data_out  out  16  driven word
- lcd_data_oe  out  1  tri-state enable for lcd_data_out
- lcd_data_in  in  16  pad input word

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - cs_n = wr_n = rd_n = 1
  - rs = 0, oe = 0, data_out = 0, readdata = 0
  - FSM = IDLE
- Reset mid-cycle: aborts to IDLE with the same values on the next edge. No DONE is produced.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- waitrequest:
  - Combinational: (avs_read | avs_write) & (state != DONE).
  - avs_read and avs_write both high at once: write wins.
- Write, addr 0/1, accepted in IDLE at cycle T:
  - rs, data_out and oe latched at T.
  - T+1 .. T+WL: cs_n = 0, wr_n = 0.
  - Next WH cycles: wr_n = 1, cs_n = 0.
  - Next cycle: DONE. cs_n = 1, oe stays 1, waitrequest = 0.
  - Then IDLE with oe = 0.
  - Defaults: DONE at T+5.
- Read, addr 2:
  - rs = 1, oe = 0 throughout.
  - T+1 .. T+RL: rd_n = 0, cs_n = 0.
  - lcd_data_in is registered into readdata[15:0] at the clock edge ending cycle T+RL; readdata[31:16] = 0.
  - Next RH cycles: rd_n = 1, cs_n = 0.
  - Then DONE.
  - Defaults: DONE at T+7. readdata holds its value until the next bus read.
- Other addresses:
  - Read of addr 0/1/3 and write of addr 2: go IDLE→DONE, waitrequest low at T+1.
  - Reads return 0. No pin activity.
- Phase counter:
  - 8-bit down-counter, loaded with the phase length minus 1 on phase entry.
  - Phase ends when the counter reaches 0.
- Back-to-back transactions: a request present in the cycle after DONE is accepted in IDLE. Minimum 1 IDLE cycle between bus cycles, so CS# stays high for ≥ 2 cycles.

Optional Feature:
- Macro: LCD_BUS_CTRL_FILL_EN.
- Defined, write to addr 3:
  - Performs N = writedata[31:16] + 1 data writes (RS = 1) of writedata[15:0].
  - cs_n held low across all of them; each write uses the WR_LO/WR_HI timing.
  - waitrequest is high until the single DONE after the last write.
  - Count register is 16 bits; count field 0 gives 1 write, 0xFFFF gives 65536 writes.
  - Reset aborts the fill.
- Undefined: a write to addr 3 completes at T+1 with no pin activity.

Decomposition:
- Package system_qsys_lcd_bus_pkg holds:
  - state encodings
  - address constants ADDR_CMD = 0, ADDR_DATA = 1, ADDR_RD = 2, ADDR_FILL = 3
  - PH_CNT_W = 8
- One sub-module, system_qsys_lcd_bus_timer:
  - loadable 8-bit phase down-counter
  - inputs: load, load value; output: expire pulse

Test Plan:
- Reset, then write addr 0 data 0x002C → RS = 0, WR# low for cycles T+1..T+2, data 0x002C with oe = 1, CS# high at T+5, waitrequest low exactly at T+5.
- Write addr 1 data 0xF800, then immediate write addr 1 data 0x07E0 → two separate CS# windows, each with WR# low 2 cycles and high 2 cycles, one IDLE cycle between them.
- Read addr 2 with lcd_data_in = 0x9341 during RD# low (changing to 0xFFFF after RD# rises) → avs_readdata = 0x00009341 at DONE (T+7), oe = 0 throughout.
- Reset asserted at cycle T+2 of a write → next edge gives cs_n = wr_n = 1, oe = 0, FSM IDLE; a fresh write then completes normally.
- Read addr 0 and write addr 2 → waitrequest low at T+1, readdata = 0, CS#/WR#/RD# never asserted.
- With LCD_BUS_CTRL_FILL_EN, write addr 3 data 0x0003_001F → 4 WR# pulses of 0x001F under one CS# low window, DONE at T+17. Without the macro → completes at T+1 with no pin toggles.
